mem_access_arbiter: RTL
=======================

Name: mem_access_arbiter

Overview:
- Shares a single memory port among NUM_REQ client modules.
- Requester 0 has fixed top priority and may preempt any other owner. Requesters 1..NUM_REQ-1 are served round-robin.
- Each grant is bounded to MAX_HOLD cycles; on expiry the grant is revoked and the owner is re-queued.
- Sits between the client modules' req/done strobes and the memory mux select.

Parameters:
NUM_REQ, 3, number of requesters (>=2); index 0 is the priority requester.
MAX_HOLD, 2, maximum ACCESS cycles per grant (>=1).
IDW, $clog2(NUM_REQ), width of owner index.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
req  input  NUM_REQ  per-requester request pulses (one or more cycles)
done  input  NUM_REQ  per-requester completion strobe
grant  output  NUM_REQ  one-hot grant, asserted only in ACCESS
owner  output  IDW  index of current/selected owner (valid in SETUP, ACCESS, RELEASE)
state  output  2  FSM state: IDLE=00, SETUP=01, ACCESS=10, RELEASE=11
pending  output  NUM_REQ  latched outstanding requests
timeout_o  output  1  one-cycle pulse when a grant is revoked by timeout
preempt_o  output  1  one-cycle pulse when a grant is revoked by requester 0

Behaviour:
- Clocking and reset:
  - One clock. Reset is synchronous and active-high; ports are named clk and reset.
  - While reset is high, at each edge: state=IDLE, grant=0, owner=0, pending=0, timeout_o=0, preempt_o=0, hold_cnt=0, rr_ptr=1.
  - req asserted in a reset cycle is dropped.
- Pending latch:
  - pending_next = (pending & ~clr) | req, where clr is the index selected/served this edge.
  - A req coincident with its own clear is retained.
  - Repeated req on an already-pending index has no extra effect.
- IDLE:
  - If pending != 0, at the next edge: owner <= winner, clear pending[winner], go to SETUP. Otherwise stay in IDLE.
  - Winner selection: index 0 if pending[0]; else the first set bit in 1..NUM_REQ-1, scanning from rr_ptr upward and wrapping to 1.
- SETUP:
  - Lasts exactly 1 cycle with grant=0 (memory address setup), then goes to ACCESS.
  - done is ignored in SETUP.
  - Latency: req sampled at edge k, SETUP visible after edge k+1, grant high after edge k+2.
- ACCESS:
  - grant[owner]=1. hold_cnt clears on entry.
  - Evaluated each cycle in this priority order:
    1. done[owner]=1: go to RELEASE. If owner!=0, rr_ptr <= owner+1, wrapping NUM_REQ -> 1.
    2. owner!=0 and pending[0]=1: go to RELEASE, set pending[owner], pulse preempt_o. rr_ptr is unchanged, so the preempted requester is next in its class.
    3. hold_cnt==MAX_HOLD-1: go to RELEASE, set pending[owner], pulse timeout_o. rr_ptr advances as in the done case.
    4. Otherwise hold_cnt++.
  - grant is therefore high for at most MAX_HOLD consecutive cycles.
  - done from a non-owner is ignored in every state.
- RELEASE:
  - Lasts 1 cycle with grant=0 (bus turnaround), then goes to IDLE.
  - Minimum gap between grants is 3 cycles (RELEASE, IDLE, SETUP).
- Pulses: timeout_o and preempt_o are registered and high for exactly the RELEASE cycle that follows the event.
- Reset mid-operation: reset during any state forces the reset values at the next edge; the interrupted owner is not re-queued.

Test Plan:
1. NUM_REQ=3, MAX_HOLD=2. Pulse req=001 in IDLE -> state 01 then 10, grant=001, owner=0. done=001 in the first ACCESS cycle -> state 11, grant=000, then 00; timeout_o stays 0.
2. Pulse req=010, never assert done -> grant=010 for exactly 2 cycles; timeout_o pulses in RELEASE; pending=010; re-granted after IDLE->SETUP.
3. From reset, pulse req=110 -> owner=1, done=010. Owner 2 is then granted, done=100, so rr_ptr=1. Pulse req=110 again -> owner=1 first. Then serve only owner 1 (rr_ptr=2) and pulse req=110 -> owner=2 wins.
4. Pulse req=111 -> owner=0 first; after done=001, owner=1 then owner=2 in order.
5. Pulse req=010; while grant=010, pulse req=001 -> preempt_o pulse, grant=000, then grant=001; after done=001, grant=010 re-issued before any other class-1 requester.
6. Assert reset during ACCESS with pending=101 -> at the next edge grant=000, pending=000, state=00, owner=0; no grant appears after reset deasserts until a new req.

Source files
------------

// File: rtl/mem_access_arbiter.sv
// mem_access_arbiter: shares one memory port among NUM_REQ clients.
// Requester 0 has fixed top priority and can preempt any other owner;
// requesters 1..NUM_REQ-1 are served round-robin. Each grant lasts at most
// MAX_HOLD ACCESS cycles. Every grant is framed by a one-cycle SETUP
// (address setup) and a one-cycle RELEASE (bus turnaround).
module mem_access_arbiter #(
   parameter int NUM_REQ  = 3,
   parameter int MAX_HOLD = 2,
   parameter int IDW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_REQ-1:0] req,
   input  logic [NUM_REQ-1:0] done,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDW-1:0]     owner,
   output logic [1:0]         state,
   output logic [NUM_REQ-1:0] pending,
   output logic               timeout_o,
   output logic               preempt_o
);

   localparam logic [1:0] ST_IDLE    = 2'b00;
   localparam logic [1:0] ST_SETUP   = 2'b01;
   localparam logic [1:0] ST_ACCESS  = 2'b10;
   localparam logic [1:0] ST_RELEASE = 2'b11;

   // hold_cnt only has to reach MAX_HOLD-1.
   localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

   logic [1:0]         state_q, state_d;
   logic [IDW-1:0]     owner_q, owner_d;
   logic [IDW-1:0]     rr_q, rr_d;
   logic [HW-1:0]      hold_q, hold_d;
   logic [NUM_REQ-1:0] pending_q, pending_d;
   logic               timeout_q, timeout_d;
   logic               preempt_q, preempt_d;

   logic [NUM_REQ-1:0] hi_mask;
   logic [NUM_REQ-1:0] hi_req;
   logic [NUM_REQ-1:0] lo_req;
   logic [IDW-1:0]     winner;
   logic [IDW-1:0]     rr_adv;
   logic [NUM_REQ-1:0] clr;
   logic [NUM_REQ-1:0] requeue;

   // Lowest set bit of a request vector (0 when empty).
   function automatic logic [IDW-1:0] lowest(input logic [NUM_REQ-1:0] v);
      lowest = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (v[i]) lowest = IDW'(i);
      end
   endfunction

   // Round-robin window: class-1 indices at or above rr_ptr are searched first.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_mask
         assign hi_mask[gi] = (gi != 0) && (IDW'(gi) >= rr_q);
      end
   endgenerate

   assign hi_req = pending_q & hi_mask;
   assign lo_req = {pending_q[NUM_REQ-1:1], 1'b0};

   // Winner: requester 0 first, else first class-1 bit from rr_ptr, wrapping to 1.
   always_comb begin
      if (pending_q[0])  winner = '0;
      else if (|hi_req)  winner = lowest(hi_req);
      else               winner = lowest(lo_req);
   end

   // Pointer after serving owner: owner+1, with NUM_REQ wrapping back to 1.
   assign rr_adv = (owner_q == IDW'(NUM_REQ - 1)) ? IDW'(1) : owner_q + IDW'(1);

   // Next-state logic of the grant FSM, pending latch and event pulses.
   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      rr_d      = rr_q;
      hold_d    = hold_q;
      clr       = '0;
      requeue   = '0;
      timeout_d = 1'b0;
      preempt_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (|pending_q) begin
               owner_d     = winner;
               clr[winner] = 1'b1;
               state_d     = ST_SETUP;
            end
         end
         ST_SETUP: begin
            state_d = ST_ACCESS;
            hold_d  = '0;
         end
         ST_ACCESS: begin
            if (done[owner_q]) begin
               state_d = ST_RELEASE;
               if (owner_q != '0) rr_d = rr_adv;
            end else if ((owner_q != '0) && pending_q[0]) begin
               // rr_ptr is left alone so the preempted client is next in its class.
               state_d          = ST_RELEASE;
               requeue[owner_q] = 1'b1;
               preempt_d        = 1'b1;
            end else if (hold_q == HW'(MAX_HOLD - 1)) begin
               state_d          = ST_RELEASE;
               requeue[owner_q] = 1'b1;
               timeout_d        = 1'b1;
               if (owner_q != '0) rr_d = rr_adv;
            end else begin
               hold_d = hold_q + HW'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      pending_d = (pending_q & ~clr) | req | requeue;
   end

   // State registers; reset drops any in-flight owner without re-queueing it.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         owner_q   <= '0;
         rr_q      <= IDW'(1);
         hold_q    <= '0;
         pending_q <= '0;
         timeout_q <= 1'b0;
         preempt_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         rr_q      <= rr_d;
         hold_q    <= hold_d;
         pending_q <= pending_d;
         timeout_q <= timeout_d;
         preempt_q <= preempt_d;
      end
   end

   // One-hot grant, only while in ACCESS.
   always_comb begin
      grant = '0;
      if (state_q == ST_ACCESS) grant[owner_q] = 1'b1;
   end

   assign owner     = owner_q;
   assign state     = state_q;
   assign pending   = pending_q;
   assign timeout_o = timeout_q;
   assign preempt_o = preempt_q;

endmodule
